adder_bist8: RTL and testbench

ADDER_BIST8 -- requirements
Module: adder_bist8

---
 rtl/adder_bist_pkg.sv | 27 ++
 rtl/bist_lfsr16.sv | 32 +++
 rtl/adder_bist8.sv | 153 +++++++++++++++
 tb/tb_adder_bist8.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_bist_pkg.sv
// Shared definitions for the 8-bit adder BIST controller.
//   state_t      : controller FSM states
//   LFSR_TAPS    : feedback taps of the right-shifting Fibonacci LFSR
//                  (x^16+x^14+x^13+x^11+1 -> state bits 0,2,3,5)
//   DEFAULT_SEED : LFSR seed used when the top is not overridden
//   CORNER_VEC   : fixed {a,b} operand pairs applied as vectors 0..3
//   lfsr_next    : one LFSR advance
package adder_bist_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        SETTLE = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [15:0] LFSR_TAPS    = 16'h002D;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    localparam logic [15:0] CORNER_VEC [4] = '{16'h0000, 16'hFF01, 16'hFFFF, 16'hAA55};

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/bist_lfsr16.sv
// 16-bit Fibonacci LFSR pattern source for the adder BIST.
//   clk, rst_n : clock, synchronous active-low reset (reset loads seed)
//   load       : reload state from seed (has priority over enable)
//   enable     : advance one step
//   seed       : reload / reset value, must be non-zero
//   state      : current LFSR state
module bist_lfsr16
    import adder_bist_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        enable,
    input  logic [15:0] seed,
    output logic [15:0] state
);

    logic [15:0] state_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= seed;
        end else if (load) begin
            state_q <= seed;
        end else if (enable) begin
            state_q <= lfsr_next(state_q);
        end
    end

    assign state = state_q;

endmodule

// File: rtl/adder_bist8.sv
// Built-in self test controller for an external 8-bit adder.
// Applies four corner vectors followed by LFSR vectors, waits SETTLE_CYC
// cycles per vector, then compares the adder's {cout,sum} with a+b.
//   clk, rst_n          : clock, synchronous active-low reset
//   start, num_vec      : launch a run of num_vec vectors (0 = 256)
//   a_o, b_o            : operands to the adder under test
//   sum_i, cout_i       : adder result, only ever sampled into registers
//   busy, done, pass    : run status
//   err_count           : mismatching vectors, saturates at 255
//   first_fail_a/_b     : operands of the first mismatching vector
//
// state  | meaning
// IDLE   | after reset, waiting for start
// DRIVE  | present next vector on a_o/b_o, advance LFSR
// SETTLE | hold operands SETTLE_CYC cycles
// CHECK  | compare adder result, count errors
// DONE   | results held, waiting for start
module adder_bist8
    import adder_bist_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 2,
    parameter logic [15:0] SEED       = DEFAULT_SEED
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] num_vec,
    output logic [7:0] a_o,
    output logic [7:0] b_o,
    input  logic [7:0] sum_i,
    input  logic       cout_i,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic [7:0] first_fail_a,
    output logic [7:0] first_fail_b
);

    localparam logic [15:0] EFF_SEED    = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [3:0]  SETTLE_LOAD = 4'(SETTLE_CYC - 1);

    state_t      state_q, state_d;
    logic [7:0]  idx_q;
    logic [8:0]  vec_count_q;
    logic [3:0]  settle_cnt_q;
    logic [15:0] lfsr_state;
    logic        launch;
    logic        last_vec;
    logic        mismatch;

    assign launch   = start && ((state_q == IDLE) || (state_q == DONE));
    assign last_vec = (({1'b0, idx_q} + 9'd1) == vec_count_q);
    assign mismatch = ({cout_i, sum_i} != ({1'b0, a_o} + {1'b0, b_o}));

    bist_lfsr16 u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (launch),
        .enable (state_q == DRIVE),
        .seed   (EFF_SEED),
        .state  (lfsr_state)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = DRIVE;
            end
            DRIVE: begin
                busy    = 1'b1;
                state_d = SETTLE;
            end
            SETTLE: begin
                busy = 1'b1;
                if (settle_cnt_q == 4'd0) state_d = CHECK;
            end
            CHECK: begin
                busy    = 1'b1;
                state_d = last_vec ? DONE : DRIVE;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_d = DRIVE;
            end
            default: state_d = IDLE;
        endcase
        pass = done && (err_count == 8'd0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_o          <= 8'h00;
            b_o          <= 8'h00;
            err_count    <= 8'h00;
            first_fail_a <= 8'h00;
            first_fail_b <= 8'h00;
            idx_q        <= 8'h00;
            vec_count_q  <= 9'd0;
            settle_cnt_q <= 4'd0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        err_count    <= 8'h00;
                        first_fail_a <= 8'h00;
                        first_fail_b <= 8'h00;
                        idx_q        <= 8'h00;
                        vec_count_q  <= (num_vec == 8'd0) ? 9'd256 : {1'b0, num_vec};
                    end
                end
                DRIVE: begin
                    // Corners first; the LFSR is stepped on every DRIVE regardless,
                    // so vector k >= 4 sees the seed advanced k times.
                    if (idx_q < 8'd4) begin
                        {a_o, b_o} <= CORNER_VEC[idx_q[1:0]];
                    end else begin
                        {a_o, b_o} <= lfsr_state;
                    end
                    settle_cnt_q <= SETTLE_LOAD;
                end
                SETTLE: begin
                    if (settle_cnt_q != 4'd0) settle_cnt_q <= settle_cnt_q - 4'd1;
                end
                CHECK: begin
                    if (mismatch) begin
                        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                        // err_count never wraps, so zero means no earlier failure
                        if (err_count == 8'h00) begin
                            first_fail_a <= a_o;
                            first_fail_b <= b_o;
                        end
                    end
                    idx_q <= idx_q + 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_bist8.sv
module tb_adder_bist8;

    localparam int S   = 2;
    localparam int PER = S + 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] num_vec;
    logic [7:0] a_o, b_o;
    logic [7:0] sum_i;
    logic       cout_i;
    logic       busy, done, pass;
    logic [7:0] err_count, first_fail_a, first_fail_b;

    int         mode;      // 0 good adder, 1 sum bit0 stuck-0, 2 sum inverted
    logic [8:0] full;
    int         errors = 0;
    int         checks = 0;
    logic [15:0] vec_log  [256];
    logic [15:0] vec_log1 [256];
    int         lat;
    bit         bad_pass;

    always #5 clk = ~clk;

    adder_bist8 #(.SETTLE_CYC(S), .SEED(16'hACE1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .num_vec      (num_vec),
        .a_o          (a_o),
        .b_o          (b_o),
        .sum_i        (sum_i),
        .cout_i       (cout_i),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .err_count    (err_count),
        .first_fail_a (first_fail_a),
        .first_fail_b (first_fail_b)
    );

    always_comb begin
        full   = {1'b0, a_o} + {1'b0, b_o};
        cout_i = full[8];
        sum_i  = full[7:0];
        if (mode == 1) sum_i[0] = 1'b0;
        else if (mode == 2) sum_i = ~full[7:0];
    end

    function automatic logic [15:0] model_step(input logic [15:0] s);
        logic fb;
        fb = s[0] ^ s[2] ^ s[3] ^ s[5];
        return {fb, s[15:1]};
    endfunction

    // Launch a run; optionally hold start high across edge number pulse_edge.
    // Returns edges from the start-sampling edge until done is seen.
    task automatic run(input logic [7:0] nv, input int pulse_edge, output int l);
        @(negedge clk);
        num_vec = nv;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        num_vec  = 8'd2;
        l        = 0;
        bad_pass = 1'b0;
        while (!done && l < 3000) begin
            start = (l + 1 == pulse_edge);
            @(posedge clk);
            #1;
            l++;
            if (!done && pass) bad_pass = 1'b1;
            if (l % PER == 1) vec_log[(l - 1) / PER] = {a_o, b_o};
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; num_vec = 8'd0; mode = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({a_o, b_o, busy, done, pass, err_count, first_fail_a, first_fail_b} !== 43'd0) begin
            errors++;
            $display("FAIL reset_outputs: got a=%h b=%h busy=%b done=%b pass=%b err=%h ffa=%h ffb=%h, need all zero",
                     a_o, b_o, busy, done, pass, err_count, first_fail_a, first_fail_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_corners();
        logic [15:0] exp_v [4];
        exp_v = '{16'h0000, 16'hFF01, 16'hFFFF, 16'hAA55};
        mode = 0;
        run(8'd4, 0, lat);
        checks++;
        if (lat !== 16) begin errors++; $display("FAIL corners_latency: got %0d, need 16", lat); end
        checks++;
        if (pass !== 1'b1 || err_count !== 8'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL corners_status: got pass=%b err=%0d busy=%b, need pass=1 err=0 busy=0", pass, err_count, busy);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (vec_log[i] !== exp_v[i]) begin
                errors++;
                $display("FAIL corner_vec%0d: got %h, need %h", i, vec_log[i], exp_v[i]);
            end
        end
        checks++;
        if (bad_pass) begin errors++; $display("FAIL pass_while_not_done: got pass=1 before done, need 0"); end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({a_o, b_o} !== 16'hAA55 || done !== 1'b1) begin
            errors++;
            $display("FAIL done_hold: got a=%h b=%h done=%b, need a=aa b=55 done=1", a_o, b_o, done);
        end
    endtask

    task automatic test_stuck_bit();
        mode = 1;
        run(8'd4, 0, lat);
        checks++;
        if (err_count !== 8'd1 || first_fail_a !== 8'hAA || first_fail_b !== 8'h55 || pass !== 1'b0) begin
            errors++;
            $display("FAIL stuck_bit0: got err=%0d ffa=%h ffb=%h pass=%b, need err=1 ffa=aa ffb=55 pass=0",
                     err_count, first_fail_a, first_fail_b, pass);
        end
        // (AA,55) is the only corner with an odd sum; a 3-vector run never reaches it
        run(8'd3, 0, lat);
        checks++;
        if (lat !== 12 || err_count !== 8'd0 || pass !== 1'b1 || {a_o, b_o} !== 16'hFFFF) begin
            errors++;
            $display("FAIL short_run3: got lat=%0d err=%0d pass=%b ab=%h, need lat=12 err=0 pass=1 ab=ffff",
                     lat, err_count, pass, {a_o, b_o});
        end
        mode = 0;
        run(8'd1, 0, lat);
        checks++;
        if (lat !== 4 || pass !== 1'b1 || {a_o, b_o} !== 16'h0000) begin
            errors++;
            $display("FAIL short_run1: got lat=%0d pass=%b ab=%h, need lat=4 pass=1 ab=0000", lat, pass, {a_o, b_o});
        end
    endtask

    task automatic test_saturate();
        logic [15:0] s;
        int bad;
        mode = 2;
        run(8'd0, 0, lat);
        checks++;
        if (lat !== 1024) begin errors++; $display("FAIL full_run_latency: got %0d, need 1024", lat); end
        checks++;
        if (err_count !== 8'd255 || pass !== 1'b0 || first_fail_a !== 8'h00 || first_fail_b !== 8'h00) begin
            errors++;
            $display("FAIL saturate: got err=%0d pass=%b ffa=%h ffb=%h, need err=255 pass=0 ffa=00 ffb=00",
                     err_count, pass, first_fail_a, first_fail_b);
        end
        s = 16'hACE1;
        for (int k = 0; k < 4; k++) s = model_step(s);
        bad = 0;
        for (int k = 4; k < 256; k++) begin
            if (vec_log[k] !== s && bad == 0)
                $display("FAIL lfsr_vec%0d: got %h, need %h", k, vec_log[k], s);
            if (vec_log[k] !== s) bad++;
            s = model_step(s);
        end
        checks++;
        if (bad != 0) errors++;
    endtask

    task automatic test_mid_reset();
        mode = 2;
        @(negedge clk);
        num_vec = 8'd4; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);   // edge 9 is vector 2's DRIVE; now in SETTLE
        #1;
        checks++;
        if (busy !== 1'b1 || err_count !== 8'd2) begin
            errors++;
            $display("FAIL mid_run_state: got busy=%b err=%0d, need busy=1 err=2", busy, err_count);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++;
        if ({a_o, b_o, busy, done, pass, err_count, first_fail_a, first_fail_b} !== 43'd0) begin
            errors++;
            $display("FAIL mid_run_reset: got a=%h b=%h busy=%b done=%b pass=%b err=%h, need all zero",
                     a_o, b_o, busy, done, pass, err_count);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got busy=%b done=%b, need 0 0", busy, done);
        end
        mode = 0;
        run(8'd4, 0, lat);
        checks++;
        if (lat !== 16 || pass !== 1'b1 || err_count !== 8'd0 || {a_o, b_o} !== 16'hAA55) begin
            errors++;
            $display("FAIL restart: got lat=%0d pass=%b err=%0d ab=%h, need lat=16 pass=1 err=0 ab=aa55",
                     lat, pass, err_count, {a_o, b_o});
        end
    endtask

    task automatic test_back_to_back();
        int diff;
        mode = 2;
        run(8'd8, 4, lat);           // start re-pulsed during CHECK of vector 0
        checks++;
        if (lat !== 32 || err_count !== 8'd8) begin
            errors++;
            $display("FAIL start_ignored: got lat=%0d err=%0d, need lat=32 err=8", lat, err_count);
        end
        for (int k = 0; k < 8; k++) vec_log1[k] = vec_log[k];
        mode = 0;
        run(8'd8, 0, lat);           // restart straight from DONE
        checks++;
        if (lat !== 32 || err_count !== 8'd0 || pass !== 1'b1) begin
            errors++;
            $display("FAIL restart_from_done: got lat=%0d err=%0d pass=%b, need lat=32 err=0 pass=1", lat, err_count, pass);
        end
        diff = 0;
        for (int k = 0; k < 8; k++) if (vec_log[k] !== vec_log1[k]) diff++;
        checks++;
        if (diff != 0) begin
            errors++;
            $display("FAIL repeat_sequence: got %0d differing vectors, need 0", diff);
        end
    endtask

    initial begin
        test_reset();
        test_corners();
        test_stuck_bit();
        test_saturate();
        test_mid_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
